// File: rtl/pc_register.sv
// pc_register: program-counter register of the single-clock MIPS core.
// Holds the address of the instruction being fetched and loads the next-PC
// value only on an instruction-cache hit; a miss stalls the PC in place.
// Optional feature macro: PC_ALIGN_CHECK_EN adds a registered `misaligned`
// flag and a simulation-time check on misaligned loads.
module pc_register #(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] next_instruction_address,
    input  logic             hit,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misaligned,
`endif
    output logic [WIDTH-1:0] instruction_address
);

    logic [WIDTH-1:0] pc_q;

    // PC register: async reset to RESET_ADDR, load verbatim on hit, else hold.
    // An unknown hit falls through to the hold branch, so X never enters pc_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_ADDR;
        end else if (hit) begin
            pc_q <= next_instruction_address;
        end
    end

    assign instruction_address = pc_q;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_q;

    // Alignment flag registered alongside pc_q; cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else if (hit) begin
            misaligned_q <= (next_instruction_address[1:0] != 2'b00);
        end
    end

    assign misaligned = misaligned_q;

    // Report any misaligned address accepted into the PC.
    a_aligned_load : assert property (
        @(posedge clock) disable iff (!reset_n)
        hit |-> (next_instruction_address[1:0] == 2'b00)
    ) else $error("pc_register: misaligned address %h loaded", next_instruction_address);
`endif

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register: table-driven edge vectors plus
// hand-written sequences for reset, mid-cycle input changes and async reset.
module tb_pc_register;

    localparam int unsigned WIDTH = 32;

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] next_instruction_address;
    logic             hit;
    logic [WIDTH-1:0] instruction_address;
`ifdef PC_ALIGN_CHECK_EN
    logic             misaligned;
`endif

    int checks;
    int errors;

    pc_register #(
        .WIDTH      (WIDTH),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .next_instruction_address (next_instruction_address),
        .hit                      (hit),
`ifdef PC_ALIGN_CHECK_EN
        .misaligned               (misaligned),
`endif
        .instruction_address      (instruction_address)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string            name;
        logic             hit;
        logic [WIDTH-1:0] next;
        logic [WIDTH-1:0] exp;
    } vec_t;

    localparam int unsigned NVEC = 13;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Wait for the next rising edge, then step 1 unit past it.
    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vec[0]  = '{"stall0",      1'b0, 32'd111,       32'd0};
        vec[1]  = '{"stall1",      1'b0, 32'd111,       32'd0};
        vec[2]  = '{"stall2",      1'b0, 32'd111,       32'd0};
        vec[3]  = '{"load111",     1'b1, 32'd111,       32'd111};
        vec[4]  = '{"load222",     1'b1, 32'd222,       32'd222};
        vec[5]  = '{"hold0",       1'b0, 32'd333,       32'd222};
        vec[6]  = '{"hold1",       1'b0, 32'd333,       32'd222};
        vec[7]  = '{"hold2",       1'b0, 32'd333,       32'd222};
        vec[8]  = '{"hold3",       1'b0, 32'd333,       32'd222};
        vec[9]  = '{"resume333",   1'b1, 32'd333,       32'd333};
        vec[10] = '{"same333",     1'b1, 32'd333,       32'd333};
        vec[11] = '{"fullwidth",   1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vec[12] = '{"allbits",     1'b1, 32'hA5A5_5A5C, 32'hA5A5_5A5C};

        // Asynchronous reset before any clock edge.
        reset_n = 1'b1;
        hit = 1'b1;
        next_instruction_address = 32'd111;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async_initial", instruction_address, 32'd0);

        // Reset held across edges with hit=1 and a toggling input.
        for (int i = 0; i < 3; i++) begin
            next_instruction_address = (i % 2 == 0) ? 32'd111 : 32'd222;
            edge_step();
            check("reset_held", instruction_address, 32'd0);
        end
`ifdef PC_ALIGN_CHECK_EN
        check("reset_misaligned", {31'd0, misaligned}, 32'd0);
`endif

        // Release reset between edges; table starts with stalls.
        hit = 1'b0;
        next_instruction_address = 32'd111;
        #2;
        reset_n = 1'b1;
        #1;
        check("release_no_edge", instruction_address, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            hit = vec[i].hit;
            next_instruction_address = vec[i].next;
            edge_step();
            check(vec[i].name, instruction_address, vec[i].exp);
        end

        // Mid-cycle input change has no effect until the next enabled edge.
        hit = 1'b1;
        next_instruction_address = 32'd111;
        edge_step();
        check("mid_load111", instruction_address, 32'd111);
        #2;
        next_instruction_address = 32'd222;
        #1;
        check("mid_still111", instruction_address, 32'd111);
        edge_step();
        check("mid_load222", instruction_address, 32'd222);

        // Hit pulsing between edges is ignored.
        hit = 1'b0;
        next_instruction_address = 32'd333;
        edge_step();
        hit = 1'b1;
        #2;
        hit = 1'b0;
        edge_step();
        check("glitch_hit_ignored", instruction_address, 32'd222);

        hit = 1'b1;
        edge_step();
        check("load333", instruction_address, 32'd333);

        // Async reset mid-operation, with a load pending.
        next_instruction_address = 32'd444;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid", instruction_address, 32'd0);
        edge_step();
        check("reset_discards_load", instruction_address, 32'd0);

        // First enabled edge after release loads.
        #2;
        reset_n = 1'b1;
        next_instruction_address = 32'h0000_0100;
        edge_step();
        check("first_load_after_reset", instruction_address, 32'h0000_0100);

        // Stored verbatim even when misaligned.
`ifdef PC_ALIGN_CHECK_EN
        next_instruction_address = 32'h0000_0006;
        edge_step();
        check("load6", instruction_address, 32'h0000_0006);
        check("misaligned6", {31'd0, misaligned}, 32'd1);
        next_instruction_address = 32'h0000_0008;
        edge_step();
        check("load8", instruction_address, 32'h0000_0008);
        check("misaligned8", {31'd0, misaligned}, 32'd0);
`else
        next_instruction_address = 32'h0000_0006;
        edge_step();
        check("load6_verbatim", instruction_address, 32'h0000_0006);
        next_instruction_address = 32'h0000_0008;
        edge_step();
        check("load8", instruction_address, 32'h0000_0008);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
